pic_pixel_fetch: RTL and testbench

//   Pixel source stage directly upstream of vga_ctrl. Takes the (h_addr, v_addr, valid) pixel request

---
 rtl/pic_pixel_fetch.sv | 152 +++++++++++++++
 tb/tb_pic_pixel_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pic_pixel_fetch.sv
// Pixel source stage feeding vga_ctrl.
// A two-stage pipeline applies a bouncing horizontal scroll offset, addresses the
// external RGB444 image ROM and widens its word to RGB888 by nibble duplication.
// The offset only moves at end of frame, so the image never tears mid-frame.
module pic_pixel_fetch #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCROLL_STEP = 1,
    parameter int X_MAX       = 639
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        valid_in,
    input  logic        scroll_en,
    output logic [18:0] rom_addr,
    input  logic [11:0] rom_q,
    output logic [23:0] data,
    output logic        data_valid,
    output logic [9:0]  x_off,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
    localparam logic [9:0]  H_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  STEP10  = 10'(SCROLL_STEP);
    localparam logic [10:0] XMAX11  = 11'(X_MAX);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2
    } state_t;

    // Scroll state
    state_t      state_reg, state_next;
    logic        dir_reg, dir_next;          // 0 = forward, 1 = reverse
    logic [9:0]  x_off_reg, x_off_next;
    logic [7:0]  frame_cnt_reg, frame_cnt_next;

    // Pipeline state
    logic [18:0] rom_addr_reg;
    logic        v1_reg;
    logic [23:0] data_reg;
    logic        data_valid_reg;

    // Combinational helpers
    logic [10:0] x_sum;
    logic [9:0]  x_eff;
    logic [10:0] fwd_sum;
    logic [23:0] expanded;
    logic        eof;

    // Each 4-bit colour channel is replicated into both halves of its 8-bit slot,
    // so full-scale 4'hF maps to 8'hFF rather than 8'hF0.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_expand
            assign expanded[gi*8 +: 8] = {rom_q[gi*4 +: 4], rom_q[gi*4 +: 4]};
        end
    endgenerate

    assign eof = pix_en & valid_in & (h_addr == H_LAST) & (v_addr == V_LAST);

    // Column address with the scroll offset, wrapped once into 0..H_ACTIVE-1
    always_comb begin
        x_sum   = {1'b0, h_addr} + {1'b0, x_off_reg};
        x_eff   = (x_sum >= H_ACT11) ? 10'(x_sum - H_ACT11) : x_sum[9:0];
        fwd_sum = {1'b0, x_off_reg} + {1'b0, STEP10};
    end

    // Scroll FSM next state: everything changes only on the end-of-frame strobe
    always_comb begin
        state_next     = state_reg;
        dir_next       = dir_reg;
        x_off_next     = x_off_reg;
        frame_cnt_next = frame_cnt_reg;
        if (eof) begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
            case (state_reg)
                ST_HOLD: begin
                    // Resuming does not move the offset; motion starts next frame.
                    if (scroll_en) begin
                        state_next = dir_reg ? ST_REV : ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (!scroll_en) begin
                        state_next = ST_HOLD;
                    end else if (fwd_sum > XMAX11) begin
                        x_off_next = x_off_reg - STEP10;
                        dir_next   = 1'b1;
                        state_next = ST_REV;
                    end else begin
                        x_off_next = fwd_sum[9:0];
                    end
                end
                ST_REV: begin
                    if (!scroll_en) begin
                        state_next = ST_HOLD;
                    end else if (x_off_reg < STEP10) begin
                        x_off_next = x_off_reg + STEP10;
                        dir_next   = 1'b0;
                        state_next = ST_FWD;
                    end else begin
                        x_off_next = x_off_reg - STEP10;
                    end
                end
                default: state_next = ST_HOLD;
            endcase
        end
    end

    // Scroll FSM and frame counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_HOLD;
            dir_reg       <= 1'b0;
            x_off_reg     <= 10'd0;
            frame_cnt_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            x_off_reg     <= x_off_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // Two-stage fetch pipeline: address the ROM, then capture and widen its data
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_reg   <= 19'd0;
            v1_reg         <= 1'b0;
            data_reg       <= 24'd0;
            data_valid_reg <= 1'b0;
        end else if (pix_en) begin
            rom_addr_reg   <= {x_eff, v_addr[8:0]};
            v1_reg         <= valid_in;
            data_reg       <= v1_reg ? expanded : 24'd0;
            data_valid_reg <= v1_reg;
        end
    end

    assign rom_addr   = rom_addr_reg;
    assign data       = data_reg;
    assign data_valid = data_valid_reg;
    assign x_off      = x_off_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_pic_pixel_fetch.sv
// Bench for pic_pixel_fetch: two instances (small bounce range and default range),
// a per-cycle comparison against a behavioural model, plus literal checkpoints.
module tb_pic_pixel_fetch;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int S0  = 4;
    localparam int XM0 = 12;
    localparam int S1  = 5;
    localparam int XM1 = 639;

    logic        clk = 1'b0;
    logic        reset, pix_en, valid_in, scroll_en;
    logic [9:0]  h_addr, v_addr;
    logic [11:0] rom_q;

    logic [18:0] a_rom_addr, b_rom_addr;
    logic [23:0] a_data, b_data;
    logic        a_dv, b_dv;
    logic [9:0]  a_x_off, b_x_off;
    logic [7:0]  a_fc, b_fc;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    pic_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .SCROLL_STEP(S0), .X_MAX(XM0)) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_addr(h_addr), .v_addr(v_addr),
        .valid_in(valid_in), .scroll_en(scroll_en), .rom_addr(a_rom_addr), .rom_q(rom_q),
        .data(a_data), .data_valid(a_dv), .x_off(a_x_off), .frame_cnt(a_fc)
    );

    pic_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .SCROLL_STEP(S1), .X_MAX(XM1)) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_addr(h_addr), .v_addr(v_addr),
        .valid_in(valid_in), .scroll_en(scroll_en), .rom_addr(b_rom_addr), .rom_q(rom_q),
        .data(b_data), .data_valid(b_dv), .x_off(b_x_off), .frame_cnt(b_fc)
    );

    // ---------------- behavioural model ----------------
    logic [18:0] m_addr[2];
    logic        m_v1[2];
    logic [23:0] m_data[2];
    logic        m_dv[2];
    int          m_xoff[2];
    int          m_fc[2];
    bit          m_move[2];
    bit          m_rev[2];

    function automatic logic [23:0] widen(input logic [11:0] q);
        logic [3:0] r, g, b;
        r = q[11:8];
        g = q[7:4];
        b = q[3:0];
        return {r, r, g, g, b, b};
    endfunction

    // Model update on every clock, mirroring the externally visible rules
    always @(posedge clk) begin
        int xs, st, xm;
        logic [9:0] xe;
        for (int k = 0; k < 2; k++) begin
            st = (k == 0) ? S0 : S1;
            xm = (k == 0) ? XM0 : XM1;
            if (reset) begin
                m_addr[k] = '0; m_v1[k] = 1'b0; m_data[k] = '0; m_dv[k] = 1'b0;
                m_xoff[k] = 0;  m_fc[k] = 0;    m_move[k] = 1'b0; m_rev[k] = 1'b0;
            end else if (pix_en) begin
                m_data[k] = m_v1[k] ? widen(rom_q) : 24'd0;
                m_dv[k]   = m_v1[k];
                xs = int'(h_addr) + m_xoff[k];
                if (xs >= H) xs = xs - H;
                xe = 10'(xs);
                m_addr[k] = {xe, v_addr[8:0]};
                m_v1[k]   = valid_in;
                if (valid_in && h_addr == 10'(H - 1) && v_addr == 10'(V - 1)) begin
                    m_fc[k] = (m_fc[k] + 1) % 256;
                    if (!m_move[k]) begin
                        if (scroll_en) m_move[k] = 1'b1;
                    end else if (!scroll_en) begin
                        m_move[k] = 1'b0;
                    end else if (!m_rev[k]) begin
                        if (m_xoff[k] + st > xm) begin
                            m_xoff[k] -= st; m_rev[k] = 1'b1;
                        end else begin
                            m_xoff[k] += st;
                        end
                    end else begin
                        if (m_xoff[k] < st) begin
                            m_xoff[k] += st; m_rev[k] = 1'b0;
                        end else begin
                            m_xoff[k] -= st;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            check("a.rom_addr", 32'(a_rom_addr), 32'(m_addr[0]));
            check("a.data",     32'(a_data),     32'(m_data[0]));
            check("a.data_valid", 32'(a_dv),     32'(m_dv[0]));
            check("a.x_off",    32'(a_x_off),    32'(m_xoff[0]));
            check("a.frame_cnt", 32'(a_fc),      32'(m_fc[0]));
            check("b.rom_addr", 32'(b_rom_addr), 32'(m_addr[1]));
            check("b.data",     32'(b_data),     32'(m_data[1]));
            check("b.data_valid", 32'(b_dv),     32'(m_dv[1]));
            check("b.x_off",    32'(b_x_off),    32'(m_xoff[1]));
            check("b.frame_cnt", 32'(b_fc),      32'(m_fc[1]));
        end
    end

    // One pixel request on a single pix_en strobe, followed by an idle clk
    task automatic strobe(input int h, input int v, input bit val, input bit sc);
        @(negedge clk);
        h_addr    = 10'(h);
        v_addr    = 10'(v);
        valid_in  = val;
        scroll_en = sc;
        pix_en    = 1'b1;
        @(negedge clk);
        pix_en    = 1'b0;
        $display("strobe h=%0d v=%0d valid=%0d scroll_en=%0d -> a.x_off=%0d a.frame_cnt=%0d",
                 h, v, val, sc, a_x_off, a_fc);
    endtask

    task automatic do_eof(input bit sc);
        strobe(H - 1, V - 1, 1'b1, sc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp5[8];
        exp5 = '{0, 4, 8, 12, 8, 4, 0, 4};

        reset = 1'b1; pix_en = 1'b0; valid_in = 1'b0; scroll_en = 1'b0;
        h_addr = '0; v_addr = '0; rom_q = '0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_on = 1'b1;
        check("reset data", 32'(a_data), 32'h0);
        check("reset x_off", 32'(a_x_off), 32'h0);

        // Basic fetch and colour widening
        rom_q = 12'hA5C;
        strobe(5, 7, 1'b1, 1'b0);
        check("t2 rom_addr", 32'(a_rom_addr), 32'((5 << 9) | 7));
        strobe(0, 0, 1'b0, 1'b0);
        check("t2 data", 32'(a_data), 32'hAA55CC);
        check("t2 data_valid", 32'(a_dv), 32'h1);

        // Out-of-area request still reads but yields black
        rom_q = 12'hFFF;
        strobe(700, 0, 1'b0, 1'b0);
        strobe(0, 0, 1'b0, 1'b0);
        check("t3 data", 32'(a_data), 32'h0);
        check("t3 data_valid", 32'(a_dv), 32'h0);

        // Last column with zero offset
        strobe(639, 0, 1'b1, 1'b0);
        check("t4 col 639", 32'(a_rom_addr[18:9]), 32'd639);

        // Bounce sequence, with a mid-frame request between every eof
        check("t5 start", 32'(a_x_off), 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_eof(1'b1);
            check("t5 x_off", 32'(a_x_off), 32'(exp5[i]));
            strobe(100, 200, 1'b1, 1'b0);
            check("t5 x_off between eofs", 32'(a_x_off), 32'(exp5[i]));
            if (i == 2) begin
                check("t4 b x_off", 32'(b_x_off), 32'd10);
                strobe(635, 0, 1'b1, 1'b1);
                check("t4 wrap col", 32'(b_rom_addr[18:9]), 32'd5);
            end
        end

        // Pause in REV at 8 and resume
        do_eof(1'b1); check("t6 eof9",  32'(a_x_off), 32'd8);
        do_eof(1'b1); check("t6 eof10", 32'(a_x_off), 32'd12);
        do_eof(1'b1); check("t6 eof11", 32'(a_x_off), 32'd8);
        do_eof(1'b0); check("t6 eof12", 32'(a_x_off), 32'd8);
        do_eof(1'b0); check("t6 eof13", 32'(a_x_off), 32'd8);
        do_eof(1'b0); check("t6 eof14", 32'(a_x_off), 32'd8);
        do_eof(1'b1); check("t6 eof15", 32'(a_x_off), 32'd8);
        do_eof(1'b1); check("t6 eof16", 32'(a_x_off), 32'd4);

        // Run out to 256 frames for the counter wrap
        for (int i = 17; i <= 255; i++) begin
            do_eof(1'($urandom_range(0, 1)));
        end
        check("fc 255", 32'(a_fc), 32'd255);
        do_eof(1'b1);
        check("fc wrap", 32'(a_fc), 32'd0);
        check("fc wrap b", 32'(b_fc), 32'd0);

        // Reset mid-frame with pixels in flight
        rom_q = 12'h123;
        strobe(10, 10, 1'b1, 1'b1);
        strobe(11, 10, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t1 rom_addr", 32'(a_rom_addr), 32'h0);
        check("t1 data", 32'(a_data), 32'h0);
        check("t1 data_valid", 32'(a_dv), 32'h0);
        check("t1 x_off", 32'(a_x_off), 32'h0);
        check("t1 frame_cnt", 32'(a_fc), 32'h0);
        strobe(0, 0, 1'b0, 1'b1);
        check("t1 flushed", 32'(a_dv), 32'h0);
        do_eof(1'b1);
        check("t1 hold start", 32'(a_x_off), 32'd0);
        do_eof(1'b1);
        check("t1 first move", 32'(a_x_off), 32'd4);
        check("t1 first move b", 32'(b_x_off), 32'd5);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
